// File: rtl/riscv_top_pkg.sv
// Shared constants for the riscv_top SoC wrapper: I/O map, UART state encoding
// and the baud divider selection.
package riscv_top_pkg;

    localparam logic [17:0] IO_BASE = 18'h30000;
    localparam logic [17:0] IO_DATA = 18'h30000;
    localparam logic [17:0] IO_CTRL = 18'h30004;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

    // Simulation builds use a short bit period so UART traffic stays cheap to simulate.
    function automatic int baud_div(input int sim, input int clk_freq, input int baud);
        return (sim != 0) ? 4 : clk_freq / baud;
    endfunction

endpackage

// File: rtl/cpu.sv
// Bus-compatible stand-in for the RV32 core: exposes the core's port list and
// keeps the byte bus idle (address 0, no writes).
module cpu (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);
    logic unused_in;
    assign unused_in = ^{clk_in, rst_in, rdy_in, mem_din, io_buffer_full};

    assign mem_dout = 8'h00;
    assign mem_a    = 32'h0000_0000;
    assign mem_wr   = 1'b0;
endmodule

// File: rtl/riscv_top_uart.sv
// 8N1 UART with a one-byte transmit hold register and a single-byte receive buffer.
module uart
    import riscv_top_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tx_wr_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_full_o,
    output logic       tx_o,
    input  logic       rx_i,
    input  logic       rx_clr_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o
);
    localparam logic [15:0] LAST = 16'(DIV - 1);
    localparam logic [15:0] HALF = 16'(DIV / 2 - 1);

    uart_state_e tx_state_q, rx_state_q;
    logic [15:0] tx_cnt_q, rx_cnt_q;
    logic [2:0]  tx_bit_q, rx_bit_q;
    logic [7:0]  tx_hold_q, tx_sh_q, rx_sh_q, rx_data_q;
    logic        tx_full_q, tx_q, rx_valid_q;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_hold_q  <= '0;
            tx_sh_q    <= '0;
            tx_full_q  <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            if (tx_wr_i && !tx_full_q) begin
                tx_hold_q <= tx_data_i;
                tx_full_q <= 1'b1;
            end
            tx_cnt_q <= (tx_cnt_q == LAST) ? '0 : tx_cnt_q + 16'd1;
            case (tx_state_q)
                IDLE: begin
                    tx_cnt_q <= '0;
                    if (tx_full_q) begin
                        tx_sh_q    <= tx_hold_q;
                        tx_full_q  <= 1'b0;
                        tx_q       <= 1'b0;
                        tx_state_q <= START;
                    end
                end
                START: if (tx_cnt_q == LAST) begin
                    tx_q       <= tx_sh_q[0];
                    tx_sh_q    <= tx_sh_q >> 1;
                    tx_bit_q   <= '0;
                    tx_state_q <= DATA;
                end
                DATA: if (tx_cnt_q == LAST) begin
                    if (tx_bit_q == 3'd7) begin
                        tx_q       <= 1'b1;
                        tx_state_q <= STOP;
                    end else begin
                        tx_q     <= tx_sh_q[0];
                        tx_sh_q  <= tx_sh_q >> 1;
                        tx_bit_q <= tx_bit_q + 3'd1;
                    end
                end
                STOP: if (tx_cnt_q == LAST) begin
                    // A waiting byte goes straight into a new start bit: no idle gap.
                    if (tx_full_q) begin
                        tx_sh_q    <= tx_hold_q;
                        tx_full_q  <= 1'b0;
                        tx_q       <= 1'b0;
                        tx_state_q <= START;
                    end else begin
                        tx_state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_s1_q   <= rx_i;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            if (rx_clr_i) rx_valid_q <= 1'b0;
            rx_cnt_q <= rx_cnt_q + 16'd1;
            case (rx_state_q)
                IDLE: begin
                    rx_cnt_q <= '0;
                    if (rx_prev_q && !rx_s2_q) rx_state_q <= START;
                end
                START: if (rx_cnt_q == HALF) begin
                    rx_cnt_q   <= '0;
                    rx_bit_q   <= '0;
                    rx_state_q <= rx_s2_q ? IDLE : DATA;
                end
                DATA: if (rx_cnt_q == LAST) begin
                    rx_cnt_q <= '0;
                    rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                    rx_bit_q <= rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_q <= STOP;
                end
                STOP: if (rx_cnt_q == LAST) begin
                    rx_cnt_q   <= '0;
                    rx_state_q <= IDLE;
                    // Placed after the clear so a completing byte beats a same-cycle read.
                    if (rx_s2_q) begin
                        rx_data_q  <= rx_sh_q;
                        rx_valid_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign tx_full_o  = tx_full_q;
    assign tx_o       = tx_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
endmodule

// File: rtl/riscv_top.sv
// SoC wrapper around the RV32 core: reset conditioning, byte-wide RAM,
// memory-mapped UART data/control and the halt LED.
module riscv_top
    import riscv_top_pkg::*;
#(
    parameter int    SIM            = 0,
    parameter int    RAM_ADDR_WIDTH = 17,
    parameter string RAM_INIT_FILE  = "test.data",
    parameter int    CLK_FREQ       = 100000000,
    parameter int    BAUD           = 115200
) (
    input  logic EXCLK,
    input  logic btnC,
    output logic Tx,
    input  logic Rx,
    output logic led
);
    localparam int DIV = baud_div(SIM, CLK_FREQ, BAUD);

    // Reset asserts immediately on btnC low and releases two clock edges after btnC rises.
    logic [1:0] rst_sync_q;
    logic       rst, rst_n;
    always_ff @(posedge EXCLK or negedge btnC) begin
        if (!btnC) rst_sync_q <= 2'b11;
        else       rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
    assign rst   = rst_sync_q[1];
    assign rst_n = ~rst;

    logic [31:0] mem_a;
    logic [7:0]  mem_dout, mem_din;
    logic        mem_wr, io_buffer_full, cpu_rdy, halted_q;

    assign cpu_rdy = ~halted_q;

    cpu u_cpu (
        .clk_in         (EXCLK),
        .rst_in         (rst),
        .rdy_in         (cpu_rdy),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    logic is_io, wr_data, wr_ctrl, rd_data, rd_ctrl;
    logic unused_addr;
    assign unused_addr = ^mem_a[31:18];
    assign is_io   = (mem_a[17:16] == IO_BASE[17:16]);
    assign wr_data = mem_wr  && (mem_a[17:0] == IO_DATA);
    assign wr_ctrl = mem_wr  && (mem_a[17:0] == IO_CTRL);
    assign rd_data = !mem_wr && (mem_a[17:0] == IO_DATA);
    assign rd_ctrl = !mem_wr && (mem_a[17:0] == IO_CTRL);

    logic [7:0] ram [2**RAM_ADDR_WIDTH];
    logic [7:0] ram_q;

    always_ff @(posedge EXCLK) begin
        if (mem_wr && !is_io) ram[mem_a[RAM_ADDR_WIDTH-1:0]] <= mem_dout;
        ram_q <= ram[mem_a[RAM_ADDR_WIDTH-1:0]];
    end

    logic [7:0] rx_data;
    logic       rx_valid;

    uart #(.DIV(DIV)) u_uart (
        .clk_i      (EXCLK),
        .rst_ni     (rst_n),
        .tx_wr_i    (wr_data),
        .tx_data_i  (mem_dout),
        .tx_full_o  (io_buffer_full),
        .tx_o       (Tx),
        .rx_i       (Rx),
        .rx_clr_i   (rd_data),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid)
    );

    // I/O read data is captured at the access edge so it lines up with the RAM's one-cycle latency.
    logic       io_sel_q;
    logic [7:0] io_rdata_q, io_rdata_d;
    always_comb begin
        io_rdata_d = 8'h00;
        if (rd_data && rx_valid) io_rdata_d = rx_data;
        else if (rd_ctrl)        io_rdata_d = {7'b0, rx_valid};
    end

    always_ff @(posedge EXCLK or negedge rst_n) begin
        if (!rst_n) begin
            io_sel_q   <= 1'b0;
            io_rdata_q <= 8'h00;
            halted_q   <= 1'b0;
        end else begin
            io_sel_q   <= is_io;
            io_rdata_q <= io_rdata_d;
            if (wr_ctrl) halted_q <= 1'b1;
        end
    end

    assign mem_din = io_sel_q ? io_rdata_q : ram_q;
    assign led     = halted_q;

    if (SIM != 0) begin : g_sim
        always_ff @(posedge EXCLK) begin
            if (rst_n && wr_data) $write("%c", mem_dout);
            if (rst_n && wr_ctrl) begin
                $display("riscv_top: program halted");
                $finish;
            end
        end
    end
endmodule

// File: tb/tb_riscv_top.sv
// Directed bench for riscv_top: drives the core's byte bus through forces and
// checks reset, RAM, UART Tx/Rx and halt behaviour against hand-derived values.
module tb_riscv_top;
    localparam logic [31:0] A_DATA = 32'h0003_0000;
    localparam logic [31:0] A_CTRL = 32'h0003_0004;
    localparam logic [31:0] A_PARK = 32'h0000_0000;

    logic clk  = 1'b0;
    logic btnC = 1'b1;
    logic Rx   = 1'b1;
    logic Tx, led;

    logic [31:0] bus_a  = 32'h0;
    logic [7:0]  bus_d  = 8'h0;
    logic        bus_wr = 1'b0;

    int total = 0;
    int bad   = 0;

    riscv_top #(
        .SIM            (0),
        .RAM_ADDR_WIDTH (17),
        .RAM_INIT_FILE  (""),
        .CLK_FREQ       (4),
        .BAUD           (1)
    ) dut (
        .EXCLK (clk),
        .btnC  (btnC),
        .Tx    (Tx),
        .Rx    (Rx),
        .led   (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic fbit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    task automatic bus_read(input logic [31:0] a, output logic [7:0] d);
        @(negedge clk);
        bus_a  = a;
        bus_wr = 1'b0;
        @(negedge clk);
        d     = dut.mem_din;
        bus_a = A_PARK;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [7:0] d, output logic [7:0] old);
        @(negedge clk);
        bus_a  = a;
        bus_d  = d;
        bus_wr = 1'b1;
        @(negedge clk);
        old    = dut.mem_din;
        bus_wr = 1'b0;
        bus_a  = A_PARK;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            Rx = (j == 9) ? stop : fbit(b, j);
            repeat (3) @(negedge clk);
        end
        @(negedge clk);
        Rx = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        logic [7:0] old;
        logic [7:0] b;
        force dut.mem_a    = bus_a;
        force dut.mem_dout = bus_d;
        force dut.mem_wr   = bus_wr;
        dut.ram[16] = 8'hA5;
        dut.ram[32] = 8'h11;

        #2 btnC = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx",   8'(Tx), 8'h01);
        chk("rst_led",  8'(led), 8'h00);
        chk("rst_int",  8'(dut.rst), 8'h01);
        chk("rst_full", 8'(dut.io_buffer_full), 8'h00);
        repeat (2) @(negedge clk);
        btnC = 1'b1;
        @(posedge clk); #1 chk("rst_edge1", 8'(dut.rst), 8'h01);
        @(posedge clk); #1 chk("rst_edge2", 8'(dut.rst), 8'h00);
        chk("post_rst_tx",  8'(Tx), 8'h01);
        chk("post_rst_rdy", 8'(dut.cpu_rdy), 8'h01);

        bus_read(32'h10, v);            chk("ram_img",  v, 8'hA5);
        bus_write(32'h10, 8'h3C, old);  chk("ram_rdw0", old, 8'hA5);
        bus_read(32'h10, v);            chk("ram_wr",   v, 8'h3C);
        bus_write(32'h20, 8'h77, old);  chk("ram_rdw1", old, 8'h11);
        bus_read(32'h20, v);            chk("ram_wr2",  v, 8'h77);
        bus_read(A_CTRL, v);            chk("io_ctrl0", v, 8'h00);
        bus_read(A_DATA, v);            chk("io_data0", v, 8'h00);
        bus_write(32'h3_0008, 8'hFF, old);
        bus_read(32'h3_0008, v);        chk("io_other", v, 8'h00);
        chk("io_other_led", 8'(led), 8'h00);

        // Single byte 0x41
        bus_write(A_DATA, 8'h41, old);
        chk("full_set", 8'(dut.io_buffer_full), 8'h01);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) chk("full_1cyc", 8'(dut.io_buffer_full), 8'h00);
            chk($sformatf("tx41_%0d", i), 8'(Tx), 8'(fbit(8'h41, i / 4)));
        end
        repeat (4) @(negedge clk);
        chk("tx_idle", 8'(Tx), 8'h01);

        // Back-to-back 0x41, 0x42
        bus_write(A_DATA, 8'h41, old);
        chk("b2b_full", 8'(dut.io_buffer_full), 8'h01);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            b = (i < 40) ? 8'h41 : 8'h42;
            chk($sformatf("b2b_%0d", i), 8'(Tx), 8'(fbit(b, (i / 4) % 10)));
            if (i == 0) begin
                chk("b2b_free", 8'(dut.io_buffer_full), 8'h00);
                bus_a = A_DATA; bus_d = 8'h42; bus_wr = 1'b1;
            end else if (i == 1) begin
                bus_wr = 1'b0; bus_a = A_PARK;
                chk("b2b_hold", 8'(dut.io_buffer_full), 8'h01);
            end
        end
        repeat (4) @(negedge clk);
        chk("b2b_idle", 8'(Tx), 8'h01);

        // Receive path
        rx_frame(8'h5A, 1'b1);
        bus_read(A_CTRL, v); chk("rx_valid1", v, 8'h01);
        bus_read(A_DATA, v); chk("rx_data",   v, 8'h5A);
        bus_read(A_CTRL, v); chk("rx_valid0", v, 8'h00);
        bus_read(A_DATA, v); chk("rx_empty",  v, 8'h00);
        rx_frame(8'h33, 1'b0);
        bus_read(A_CTRL, v); chk("rx_frmerr", v, 8'h00);
        rx_frame(8'h11, 1'b1);
        rx_frame(8'hC4, 1'b1);
        bus_read(A_CTRL, v); chk("rx_ovr_vld",  v, 8'h01);
        bus_read(A_DATA, v); chk("rx_overrun",  v, 8'hC4);

        // Halt, then reset in the middle of a Tx frame
        chk("pre_halt_led", 8'(led), 8'h00);
        bus_write(A_CTRL, 8'h00, old);
        chk("halt_led", 8'(led), 8'h01);
        chk("halt_rdy", 8'(dut.cpu_rdy), 8'h00);
        repeat (3) @(negedge clk);
        chk("halt_latched", 8'(led), 8'h01);
        bus_write(A_DATA, 8'h00, old);
        repeat (6) @(negedge clk);
        chk("mid_frame_tx", 8'(Tx), 8'h00);
        btnC = 1'b0;
        #1;
        chk("abort_tx",   8'(Tx), 8'h01);
        chk("abort_led",  8'(led), 8'h00);
        chk("abort_full", 8'(dut.io_buffer_full), 8'h00);
        repeat (2) @(negedge clk);
        btnC = 1'b1;
        repeat (4) @(negedge clk);
        chk("rerst_led", 8'(led), 8'h00);
        chk("rerst_rdy", 8'(dut.cpu_rdy), 8'h01);
        chk("rerst_tx",  8'(Tx), 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
